// File: rtl/alu_simd_pkg.sv
// Shared SIMD definitions for the ALU and its output stage: slice geometry,
// mode encodings, lane membership and the top-slice table used for carries.
package alu_simd_pkg;

    localparam int DATA_W   = 90;
    localparam int N_SLICES = 8;
    localparam int N_LANES  = 8;

    localparam int SLICE_W   [N_SLICES] = '{26, 10, 8, 10, 8, 10, 8, 10};
    localparam int SLICE_LSB [N_SLICES] = '{0, 26, 36, 44, 54, 62, 72, 80};

    typedef enum logic [1:0] {
        SIMD_ONE   = 2'b00,
        SIMD_TWO   = 2'b01,
        SIMD_FOUR  = 2'b10,
        SIMD_EIGHT = 2'b11
    } simd_mode_e;

    // Highest slice of each lane; its odd carry bit is the lane carry.
    localparam int TOP_SLICE [4][N_LANES] = '{
        '{7, 0, 0, 0, 0, 0, 0, 0},
        '{3, 7, 0, 0, 0, 0, 0, 0},
        '{1, 3, 5, 7, 0, 0, 0, 0},
        '{0, 1, 2, 3, 4, 5, 6, 7}
    };

    function automatic logic [DATA_W-1:0] slice_bits(input int s);
        logic [DATA_W-1:0] ones;
        ones = '1;
        return (ones >> (DATA_W - SLICE_W[s])) << SLICE_LSB[s];
    endfunction

    function automatic logic [N_SLICES-1:0] lane_mask(input simd_mode_e mode, input int lane);
        int n_lanes;
        int per_lane;
        logic [N_SLICES-1:0] ones;
        n_lanes  = 1 << int'(mode);
        per_lane = N_SLICES >> int'(mode);
        ones     = '1;
        if (lane >= n_lanes) return '0;
        return (ones >> (N_SLICES - per_lane)) << (lane * per_lane);
    endfunction

endpackage

// File: rtl/alu_lane_pattern_detect.sv
// Combinational per-lane pattern / inverse-pattern match and lane carry
// selection for one candidate P value in the given SIMD mode.
module alu_lane_pattern_detect
    import alu_simd_pkg::*;
#(
    parameter logic [DATA_W-1:0] PATTERN = '0,
    parameter logic [DATA_W-1:0] MASK    = '0
) (
    input  logic [DATA_W-1:0]     value_i,
    input  simd_mode_e            mode_i,
    input  logic [2*N_SLICES-1:0] carry_out_i,
    output logic [N_LANES-1:0]    pd_o,
    output logic [N_LANES-1:0]    pbd_o,
    output logic [N_LANES-1:0]    carry_o
);

    logic [DATA_W-1:0]   diff_pd;
    logic [DATA_W-1:0]   diff_pbd;
    logic [N_SLICES-1:0] slice_pd;
    logic [N_SLICES-1:0] slice_pbd;
    logic [N_SLICES-1:0] slice_carry;

    always_comb begin
        diff_pd  = (value_i ^ PATTERN) & ~MASK;
        diff_pbd = (value_i ^ ~PATTERN) & ~MASK;
        for (int s = 0; s < N_SLICES; s++) begin
            slice_pd[s]    = ~|(diff_pd & slice_bits(s));
            slice_pbd[s]   = ~|(diff_pbd & slice_bits(s));
            slice_carry[s] = carry_out_i[2*s+1];
        end
        // A lane matches only when every slice it owns matches; unused lanes read 0.
        for (int k = 0; k < N_LANES; k++) begin
            pd_o[k]    = (lane_mask(mode_i, k) != '0) && ((lane_mask(mode_i, k) & ~slice_pd) == '0);
            pbd_o[k]   = (lane_mask(mode_i, k) != '0) && ((lane_mask(mode_i, k) & ~slice_pbd) == '0);
            carry_o[k] = (lane_mask(mode_i, k) != '0)
                         && (|(slice_carry & (8'b1 << TOP_SLICE[mode_i][k])));
        end
    end

endmodule

// File: rtl/alu_simd_output_stage.sv
// Output register stage behind the 90-bit SIMD ALU: P accumulator register,
// per-lane carry, pattern detect, overflow/underflow and optional auto-reset.
module alu_simd_output_stage
    import alu_simd_pkg::*;
#(
    parameter logic [89:0] PATTERN          = 90'h0,
    parameter logic [89:0] MASK             = 90'h0,
    parameter int          AUTORESET_PATDET = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CEP,
    input  logic [1:0]  USE_SIMD,
    input  logic [89:0] S,
    input  logic [15:0] result_SIDM_carry_out,
    output logic [89:0] P,
    output logic [7:0]  CARRYOUT,
    output logic [7:0]  PATTERNDETECT,
    output logic [7:0]  PATTERNBDETECT,
    output logic [7:0]  OVERFLOW,
    output logic [7:0]  UNDERFLOW
);

    simd_mode_e  mode_q, mode_d;
    logic [89:0] p_q, p_d;
    logic [7:0]  carry_q, carry_d, carry_raw;
    logic [7:0]  pd_q, pd_d, pbd_q, pbd_d;
    logic [7:0]  of_q, of_d, uf_q, uf_d;
    logic [7:0]  pd_past_q, pd_past_d, pbd_past_q, pbd_past_d;
    logic [7:0]  fire, clear_slices, lane_cleared, same_mode;
    logic [89:0] clear_bits;

    assign mode_d = simd_mode_e'(USE_SIMD);

    alu_lane_pattern_detect #(
        .PATTERN (PATTERN),
        .MASK    (MASK)
    ) u_detect (
        .value_i     (p_d),
        .mode_i      (mode_d),
        .carry_out_i (result_SIDM_carry_out),
        .pd_o        (pd_d),
        .pbd_o       (pbd_d),
        .carry_o     (carry_raw)
    );

    always_comb begin
        case (AUTORESET_PATDET)
            1:       fire = pd_q;
            2:       fire = of_q | uf_q;
            default: fire = '0;
        endcase
        // Firing flags belong to the lanes of the mode they were computed in.
        clear_slices = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (fire[k]) clear_slices = clear_slices | lane_mask(mode_q, k);
        end
        clear_bits = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            if (clear_slices[s]) clear_bits = clear_bits | slice_bits(s);
        end
        p_d = S & ~clear_bits;
        for (int k = 0; k < N_LANES; k++) begin
            lane_cleared[k] = |(lane_mask(mode_d, k) & clear_slices);
        end
        carry_d = carry_raw & ~lane_cleared;

        // Past flags from another lane layout are meaningless, so a mode change voids them.
        same_mode  = {8{mode_d == mode_q}};
        of_d       = pd_past_q & ~pd_d & ~pbd_d & same_mode;
        uf_d       = pbd_past_q & ~pd_d & ~pbd_d & same_mode;
        pd_past_d  = pd_d & same_mode;
        pbd_past_d = pbd_d & same_mode;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= SIMD_ONE;
            p_q        <= '0;
            carry_q    <= '0;
            pd_q       <= '0;
            pbd_q      <= '0;
            of_q       <= '0;
            uf_q       <= '0;
            pd_past_q  <= '0;
            pbd_past_q <= '0;
        end else if (CEP) begin
            mode_q     <= mode_d;
            p_q        <= p_d;
            carry_q    <= carry_d;
            pd_q       <= pd_d;
            pbd_q      <= pbd_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
            pd_past_q  <= pd_past_d;
            pbd_past_q <= pbd_past_d;
        end
    end

    assign P              = p_q;
    assign CARRYOUT       = carry_q;
    assign PATTERNDETECT  = pd_q;
    assign PATTERNBDETECT = pbd_q;
    assign OVERFLOW       = of_q;
    assign UNDERFLOW      = uf_q;

endmodule

// File: tb/tb_alu_simd_output_stage.sv
// Self-checking bench: three parameterisations share one stimulus stream and
// are compared against a bit-range reference model every clock.
module tb_alu_simd_output_stage;

    localparam logic [89:0] PAT_C  = 90'h2ABCDEF0123456789ABCDEF;
    localparam logic [89:0] MASK_C = 90'h00F0000FF000000000F0F00;

    localparam int SB [9] = '{0, 26, 36, 44, 54, 62, 72, 80, 90};
    localparam int NL [4] = '{1, 2, 4, 8};
    localparam int LANE_LO [4][8] = '{
        '{0, -1, -1, -1, -1, -1, -1, -1},
        '{0, 54, -1, -1, -1, -1, -1, -1},
        '{0, 36, 54, 72, -1, -1, -1, -1},
        '{0, 26, 36, 44, 54, 62, 72, 80}
    };
    localparam int LANE_HI [4][8] = '{
        '{89, -1, -1, -1, -1, -1, -1, -1},
        '{53, 89, -1, -1, -1, -1, -1, -1},
        '{35, 53, 71, 89, -1, -1, -1, -1},
        '{25, 35, 43, 53, 61, 71, 79, 89}
    };

    typedef struct {
        logic [89:0] p;
        logic [7:0]  co, pd, pbd, of, uf, pdp, pbdp;
        logic [1:0]  mode;
    } model_t;

    logic        clk = 1'b0;
    logic        reset, CEP;
    logic [1:0]  USE_SIMD;
    logic [89:0] S;
    logic [15:0] co_in;

    logic [89:0] p_a, p_b, p_c;
    logic [7:0]  co_a, pd_a, pbd_a, of_a, uf_a;
    logic [7:0]  co_b, pd_b, pbd_b, of_b, uf_b;
    logic [7:0]  co_c, pd_c, pbd_c, of_c, uf_c;

    int checks = 0;
    int errors = 0;
    model_t ma, mb, mc;

    always #5 clk = ~clk;

    alu_simd_output_stage #(.PATTERN(90'h0), .MASK(90'h0), .AUTORESET_PATDET(0)) dut_a (
        .clk(clk), .reset(reset), .CEP(CEP), .USE_SIMD(USE_SIMD), .S(S),
        .result_SIDM_carry_out(co_in), .P(p_a), .CARRYOUT(co_a), .PATTERNDETECT(pd_a),
        .PATTERNBDETECT(pbd_a), .OVERFLOW(of_a), .UNDERFLOW(uf_a));

    alu_simd_output_stage #(.PATTERN(90'h0), .MASK(90'h0), .AUTORESET_PATDET(1)) dut_b (
        .clk(clk), .reset(reset), .CEP(CEP), .USE_SIMD(USE_SIMD), .S(S),
        .result_SIDM_carry_out(co_in), .P(p_b), .CARRYOUT(co_b), .PATTERNDETECT(pd_b),
        .PATTERNBDETECT(pbd_b), .OVERFLOW(of_b), .UNDERFLOW(uf_b));

    alu_simd_output_stage #(.PATTERN(PAT_C), .MASK(MASK_C), .AUTORESET_PATDET(2)) dut_c (
        .clk(clk), .reset(reset), .CEP(CEP), .USE_SIMD(USE_SIMD), .S(S),
        .result_SIDM_carry_out(co_in), .P(p_c), .CARRYOUT(co_c), .PATTERNDETECT(pd_c),
        .PATTERNBDETECT(pbd_c), .OVERFLOW(of_c), .UNDERFLOW(uf_c));

    task automatic check(input string tag, input logic [89:0] got, input logic [89:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: lanes are explicit bit ranges; flags follow the written rules directly.
    function automatic model_t step(input model_t st, input logic r, input logic cep,
                                    input logic [1:0] m, input logic [89:0] s,
                                    input logic [15:0] co, input logic [89:0] pat,
                                    input logic [89:0] mask, input int ar);
        model_t n;
        logic [89:0] cleared;
        logic pdk, pbdk, fire, hit, changed;
        int j;
        n = st;
        if (r) begin
            n = '{default: '0};
        end else if (cep) begin
            cleared = '0;
            for (int k = 0; k < NL[st.mode]; k++) begin
                fire = (ar == 1 && st.pd[k]) || (ar == 2 && (st.of[k] || st.uf[k]));
                if (fire) for (int b = LANE_LO[st.mode][k]; b <= LANE_HI[st.mode][k]; b++) cleared[b] = 1'b1;
            end
            n.p = s & ~cleared;
            n.pd = '0; n.pbd = '0; n.co = '0;
            for (int k = 0; k < NL[m]; k++) begin
                pdk = 1'b1; pbdk = 1'b1; hit = 1'b0;
                for (int b = LANE_LO[m][k]; b <= LANE_HI[m][k]; b++) begin
                    if (!mask[b] && n.p[b] != pat[b]) pdk = 1'b0;
                    if (!mask[b] && n.p[b] == pat[b]) pbdk = 1'b0;
                    if (cleared[b]) hit = 1'b1;
                end
                j = 0;
                for (int t = 0; t < 8; t++) if (SB[t+1] - 1 == LANE_HI[m][k]) j = t;
                n.pd[k]  = pdk;
                n.pbd[k] = pbdk;
                n.co[k]  = co[2*j+1] && !hit;
            end
            changed = (m != st.mode);
            n.of   = changed ? 8'h0 : (st.pdp & ~n.pd & ~n.pbd);
            n.uf   = changed ? 8'h0 : (st.pbdp & ~n.pd & ~n.pbd);
            n.pdp  = changed ? 8'h0 : n.pd;
            n.pbdp = changed ? 8'h0 : n.pbd;
            n.mode = m;
        end
        return n;
    endfunction

    task automatic check_dut(input string nm, input model_t m, input logic [89:0] p,
                             input logic [7:0] co, input logic [7:0] pd, input logic [7:0] pbd,
                             input logic [7:0] of, input logic [7:0] uf);
        check({nm, ".P"}, p, m.p);
        check({nm, ".CARRYOUT"}, {82'h0, co}, {82'h0, m.co});
        check({nm, ".PD"}, {82'h0, pd}, {82'h0, m.pd});
        check({nm, ".PBD"}, {82'h0, pbd}, {82'h0, m.pbd});
        check({nm, ".OVF"}, {82'h0, of}, {82'h0, m.of});
        check({nm, ".UNF"}, {82'h0, uf}, {82'h0, m.uf});
    endtask

    task automatic cycle(input logic r, input logic cep, input logic [1:0] m,
                         input logic [89:0] s, input logic [15:0] co);
        reset = r; CEP = cep; USE_SIMD = m; S = s; co_in = co;
        @(posedge clk);
        ma = step(ma, r, cep, m, s, co, 90'h0, 90'h0, 0);
        mb = step(mb, r, cep, m, s, co, 90'h0, 90'h0, 1);
        mc = step(mc, r, cep, m, s, co, PAT_C, MASK_C, 2);
        #1;
        check_dut("a", ma, p_a, co_a, pd_a, pbd_a, of_a, uf_a);
        check_dut("b", mb, p_b, co_b, pd_b, pbd_b, of_b, uf_b);
        check_dut("c", mc, p_c, co_c, pd_c, pbd_c, of_c, uf_c);
    endtask

    function automatic logic [89:0] rand90();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    // Every slice gets at least one set bit so no slice matches a zero pattern.
    function automatic logic [89:0] rand_nz();
        logic [89:0] v;
        v = rand90();
        for (int s = 0; s < 8; s++) v[SB[s]] = 1'b1;
        return v;
    endfunction

    function automatic logic [89:0] rand_biased();
        logic [89:0] v, r;
        int src;
        r = rand90();
        v = '0;
        for (int s = 0; s < 8; s++) begin
            src = $urandom_range(0, 4);
            for (int b = SB[s]; b < SB[s+1]; b++) begin
                case (src)
                    0: v[b] = 1'b0;
                    1: v[b] = 1'b1;
                    2: v[b] = PAT_C[b];
                    3: v[b] = ~PAT_C[b];
                    default: v[b] = r[b];
                endcase
            end
        end
        return v;
    endfunction

    initial begin
        logic [89:0] s_tmp, s_z2, m2;
        logic [1:0]  mode;
        ma = '{default: '0}; mb = '{default: '0}; mc = '{default: '0};
        m2 = 90'hFF;
        m2 = m2 << 36;

        // Reset wins over CEP with all-ones data.
        cycle(1'b1, 1'b1, 2'b00, '1, 16'hFFFF);
        check("rst.P", p_a, 90'h0);
        check("rst.flags", {50'h0, co_a, pd_a, pbd_a, of_a, uf_a}, 90'h0);

        s_tmp = rand_nz();
        cycle(1'b0, 1'b1, 2'b00, s_tmp, 16'h0);
        check("release.P", p_a, s_tmp);

        cycle(1'b0, 1'b1, 2'b00, 90'h0, 16'h0);
        check("m0.pd_zero", {82'h0, pd_a}, 90'h01);
        cycle(1'b0, 1'b1, 2'b00, 90'h1, 16'h0);
        check("m0.pd_fall", {82'h0, pd_a}, 90'h0);
        check("m0.overflow", {82'h0, of_a}, 90'h01);

        cycle(1'b0, 1'b1, 2'b01, {36'h1, 54'h0}, 16'h0080);
        check("m1.pd_lane0", {82'h0, pd_a}, 90'h01);
        check("m1.carry_lane0", {82'h0, co_a}, 90'h01);

        // Build pd_past=1 in mode 00, then switch to mode 10.
        cycle(1'b0, 1'b1, 2'b00, 90'h0, 16'h0);
        cycle(1'b0, 1'b1, 2'b00, 90'h0, 16'h0);
        cycle(1'b0, 1'b1, 2'b10, 90'h1, 16'h0);
        check("switch.no_ovf", {82'h0, of_a}, 90'h0);

        // Auto-reset on PATTERNDETECT in eight-slice mode.
        cycle(1'b1, 1'b1, 2'b11, rand90(), 16'h0);
        cycle(1'b0, 1'b1, 2'b11, rand_nz(), 16'h0);
        s_z2 = rand_nz() & ~m2;
        cycle(1'b0, 1'b1, 2'b11, s_z2, 16'hFFFF);
        check("ar.pd2", {82'h0, pd_b}, 90'h04);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2'b11, rand90(), 16'($urandom));
            check("hold.P", p_b, s_z2);
            check("hold.pd", {82'h0, pd_b}, 90'h04);
        end
        s_tmp = rand_nz();
        cycle(1'b0, 1'b1, 2'b11, s_tmp, 16'hFFFF);
        check("ar.P_cleared", p_b, s_tmp & ~m2);
        check("ar.carry_cleared", {82'h0, co_b}, 90'hFB);

        // Randomised run across modes, enables and resets.
        mode = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, mode,
                  rand_biased(), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
